inst_data_arbiter: RTL and testbench

- Shares one SRAM-like memory bus between the fetch-stage instruction port and the mem-stage data port of the 5-stage MIPS core.
- Sits between the datapath/controller and the bus bridge.
- Allows one outstanding transaction at a time. Data has fixed priority over instruction, because the data access belongs to the older instruction.
- Supports cancelling an in-flight fetch when an exception or eret flush occurs.

---
 rtl/inst_data_arbiter_pkg.sv | 20 ++
 rtl/inst_data_arbiter_if.sv | 56 +++++
 rtl/inst_data_arbiter.sv | 124 ++++++++++++
 tb/tb_inst_data_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_data_arbiter_pkg.sv
// rtl/inst_data_arbiter_pkg.sv - shared encodings for the inst/data bus arbiter
package inst_data_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/inst_data_arbiter_if.sv
// rtl/inst_data_arbiter_if.sv - fetch, load/store and shared-bus handshake bundle
interface inst_data_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  inst_req;
  logic [ADDR_W-1:0]     inst_addr;
  logic                  inst_addr_ok;
  logic                  inst_data_ok;
  logic [DATA_W-1:0]     inst_rdata;
  logic                  inst_cancel;

  logic                  data_req;
  logic                  data_wr;
  logic [1:0]            data_size;
  logic [ADDR_W-1:0]     data_addr;
  logic [DATA_W/8-1:0]   data_wstrb;
  logic [DATA_W-1:0]     data_wdata;
  logic                  data_addr_ok;
  logic                  data_data_ok;
  logic [DATA_W-1:0]     data_rdata;

  logic                  bus_req;
  logic                  bus_wr;
  logic [1:0]            bus_size;
  logic [ADDR_W-1:0]     bus_addr;
  logic [DATA_W/8-1:0]   bus_wstrb;
  logic [DATA_W-1:0]     bus_wdata;
  logic                  bus_addr_ok;
  logic                  bus_data_ok;
  logic [DATA_W-1:0]     bus_rdata;

  logic                  busy;

  // slave: the arbiter itself; master: everything around it (core + bus bridge)
  modport slave (
    input  inst_req, inst_addr, inst_cancel,
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata,
    output busy
  );

  modport master (
    output inst_req, inst_addr, inst_cancel,
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata,
    input  busy
  );

endinterface

// File: rtl/inst_data_arbiter.sv
// rtl/inst_data_arbiter.sv - one-outstanding arbiter sharing the memory bus between fetch and mem stage
module inst_data_arbiter
  import inst_data_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  inst_data_arbiter_if.slave io
);

  state_e                state_q;
  owner_e                owner_q;
  logic                  drop_q;
  logic                  bus_req_q;
  logic                  bus_wr_q;
  logic [1:0]            bus_size_q;
  logic [ADDR_W-1:0]     bus_addr_q;
  logic [DATA_W/8-1:0]   bus_wstrb_q;
  logic [DATA_W-1:0]     bus_wdata_q;

  logic addr_hs;
  logic data_fire;
  logic inst_kill;
  logic own_inst;
  logic own_data;

  always_comb begin
    addr_hs   = (state_q == ST_ADDR) && io.bus_addr_ok;
    // a response arriving with the address handshake completes the transfer at once
    data_fire = ((state_q == ST_DATA) || addr_hs) && io.bus_data_ok;
    own_inst  = (owner_q == OWN_INST);
    own_data  = (owner_q == OWN_DATA);
    inst_kill = drop_q || (io.inst_cancel && own_inst);
  end

  assign io.inst_addr_ok = addr_hs && own_inst && !inst_kill;
  assign io.inst_data_ok = data_fire && own_inst && !inst_kill;
  assign io.inst_rdata   = io.inst_data_ok ? io.bus_rdata : '0;
  assign io.data_addr_ok = addr_hs && own_data;
  assign io.data_data_ok = data_fire && own_data;
  assign io.data_rdata   = io.data_data_ok ? io.bus_rdata : '0;

  assign io.bus_req   = bus_req_q;
  assign io.bus_wr    = bus_wr_q;
  assign io.bus_size  = bus_size_q;
  assign io.bus_addr  = bus_addr_q;
  assign io.bus_wstrb = bus_wstrb_q;
  assign io.bus_wdata = bus_wdata_q;
  assign io.busy      = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_NONE;
      drop_q      <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_size_q  <= 2'd0;
      bus_addr_q  <= '0;
      bus_wstrb_q <= '0;
      bus_wdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          drop_q <= 1'b0;
          // data belongs to the older instruction, so it always wins arbitration
          if (io.data_req) begin
            bus_req_q   <= 1'b1;
            bus_wr_q    <= io.data_wr;
            bus_size_q  <= io.data_size;
            bus_addr_q  <= io.data_addr;
            bus_wstrb_q <= io.data_wstrb;
            bus_wdata_q <= io.data_wdata;
            owner_q     <= OWN_DATA;
            state_q     <= ST_ADDR;
          end else if (io.inst_req && !io.inst_cancel) begin
            bus_req_q   <= 1'b1;
            bus_wr_q    <= 1'b0;
            bus_size_q  <= SIZE_WORD;
            bus_addr_q  <= io.inst_addr;
            bus_wstrb_q <= '0;
            bus_wdata_q <= '0;
            owner_q     <= OWN_INST;
            state_q     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (io.inst_cancel && own_inst) begin
            drop_q <= 1'b1;
          end
          if (addr_hs) begin
            bus_req_q <= 1'b0;
            if (io.bus_data_ok) begin
              state_q <= ST_IDLE;
              owner_q <= OWN_NONE;
              drop_q  <= 1'b0;
            end else begin
              state_q <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (io.inst_cancel && own_inst) begin
            drop_q <= 1'b1;
          end
          if (io.bus_data_ok) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_NONE;
            drop_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          owner_q   <= OWN_NONE;
          drop_q    <= 1'b0;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_data_arbiter.sv
// tb/tb_inst_data_arbiter.sv - directed self-checking bench for inst_data_arbiter
module tb_inst_data_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  inst_data_arbiter_if #(.ADDR_W(32), .DATA_W(32)) io ();

  inst_data_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    io.inst_req = 0; io.inst_addr = '0; io.inst_cancel = 0;
    io.data_req = 0; io.data_wr = 0; io.data_size = 0; io.data_addr = '0;
    io.data_wstrb = '0; io.data_wdata = '0;
    io.bus_addr_ok = 0; io.bus_data_ok = 0; io.bus_rdata = '0;

    // reset state
    @(negedge clk);
    chk("rst_bus_req", 32'(io.bus_req), 32'd0);
    chk("rst_bus_addr", io.bus_addr, 32'd0);
    chk("rst_bus_wdata", io.bus_wdata, 32'd0);
    chk("rst_busy", 32'(io.busy), 32'd0);
    chk("rst_inst_rdata", io.inst_rdata, 32'd0);
    next_cycle();
    rst = 1'b1;
    next_cycle();

    // 1: plain fetch, zero-wait address, data two cycles later
    io.inst_req = 1; io.inst_addr = 32'hBFC00000;
    @(negedge clk);
    chk("f1_t_bus_req", 32'(io.bus_req), 32'd0);
    next_cycle();
    io.bus_addr_ok = 1;
    @(negedge clk);
    chk("f1_bus_req", 32'(io.bus_req), 32'd1);
    chk("f1_bus_addr", io.bus_addr, 32'hBFC00000);
    chk("f1_bus_size", 32'(io.bus_size), 32'd2);
    chk("f1_bus_wr", 32'(io.bus_wr), 32'd0);
    chk("f1_inst_addr_ok", 32'(io.inst_addr_ok), 32'd1);
    chk("f1_data_addr_ok", 32'(io.data_addr_ok), 32'd0);
    next_cycle();
    io.inst_req = 0; io.bus_addr_ok = 0;
    @(negedge clk);
    chk("f1_t2_bus_req", 32'(io.bus_req), 32'd0);
    chk("f1_t2_inst_data_ok", 32'(io.inst_data_ok), 32'd0);
    chk("f1_t2_busy", 32'(io.busy), 32'd1);
    next_cycle();
    io.bus_data_ok = 1; io.bus_rdata = 32'h3C08BFAF;
    @(negedge clk);
    chk("f1_inst_data_ok", 32'(io.inst_data_ok), 32'd1);
    chk("f1_inst_rdata", io.inst_rdata, 32'h3C08BFAF);
    chk("f1_data_data_ok", 32'(io.data_data_ok), 32'd0);
    next_cycle();
    io.bus_data_ok = 0;
    @(negedge clk);
    chk("f1_t4_busy", 32'(io.busy), 32'd0);
    next_cycle();

    // 2: simultaneous store and fetch, store goes first
    io.inst_req = 1; io.inst_addr = 32'hBFC00004;
    io.data_req = 1; io.data_wr = 1; io.data_size = 2'd2; io.data_addr = 32'h80000010;
    io.data_wstrb = 4'hF; io.data_wdata = 32'h12345678;
    @(negedge clk);
    chk("s2_t_inst_addr_ok", 32'(io.inst_addr_ok), 32'd0);
    next_cycle();
    io.bus_addr_ok = 1;
    @(negedge clk);
    chk("s2_bus_wr", 32'(io.bus_wr), 32'd1);
    chk("s2_bus_addr", io.bus_addr, 32'h80000010);
    chk("s2_bus_wstrb", 32'(io.bus_wstrb), 32'hF);
    chk("s2_bus_wdata", io.bus_wdata, 32'h12345678);
    chk("s2_data_addr_ok", 32'(io.data_addr_ok), 32'd1);
    chk("s2_inst_addr_ok", 32'(io.inst_addr_ok), 32'd0);
    next_cycle();
    io.data_req = 0; io.bus_addr_ok = 0; io.bus_data_ok = 1; io.bus_rdata = 32'h0;
    @(negedge clk);
    chk("s2_data_data_ok", 32'(io.data_data_ok), 32'd1);
    chk("s2_inst_data_ok", 32'(io.inst_data_ok), 32'd0);
    next_cycle();
    io.bus_data_ok = 0;
    @(negedge clk);
    chk("s2_idle_bus_req", 32'(io.bus_req), 32'd0);
    chk("s2_idle_busy", 32'(io.busy), 32'd0);
    next_cycle();
    io.bus_addr_ok = 1;
    @(negedge clk);
    chk("s2_f_bus_req", 32'(io.bus_req), 32'd1);
    chk("s2_f_bus_addr", io.bus_addr, 32'hBFC00004);
    chk("s2_f_bus_wr", 32'(io.bus_wr), 32'd0);
    chk("s2_f_bus_wstrb", 32'(io.bus_wstrb), 32'd0);
    chk("s2_f_inst_addr_ok", 32'(io.inst_addr_ok), 32'd1);
    next_cycle();
    io.inst_req = 0; io.bus_addr_ok = 0; io.bus_data_ok = 1; io.bus_rdata = 32'h24080001;
    @(negedge clk);
    chk("s2_f_inst_data_ok", 32'(io.inst_data_ok), 32'd1);
    chk("s2_f_inst_rdata", io.inst_rdata, 32'h24080001);
    next_cycle();
    io.bus_data_ok = 0;
    next_cycle();

    // 3: fetch cancelled while waiting for data
    io.inst_req = 1; io.inst_addr = 32'hBFC00008;
    next_cycle();
    io.bus_addr_ok = 1;
    @(negedge clk);
    chk("c3_inst_addr_ok", 32'(io.inst_addr_ok), 32'd1);
    next_cycle();
    io.inst_req = 0; io.bus_addr_ok = 0; io.inst_cancel = 1;
    @(negedge clk);
    chk("c3_cancel_data_ok", 32'(io.inst_data_ok), 32'd0);
    next_cycle();
    io.inst_cancel = 0; io.bus_data_ok = 1; io.bus_rdata = 32'h11111111;
    @(negedge clk);
    chk("c3_dropped_data_ok", 32'(io.inst_data_ok), 32'd0);
    chk("c3_dropped_rdata", io.inst_rdata, 32'd0);
    next_cycle();
    io.bus_data_ok = 0; io.inst_req = 1; io.inst_addr = 32'hBFC00380;
    @(negedge clk);
    chk("c3_idle_busy", 32'(io.busy), 32'd0);
    next_cycle();
    io.bus_addr_ok = 1;
    @(negedge clk);
    chk("c3_next_bus_addr", io.bus_addr, 32'hBFC00380);
    chk("c3_next_addr_ok", 32'(io.inst_addr_ok), 32'd1);
    next_cycle();
    io.inst_req = 0; io.bus_addr_ok = 0; io.bus_data_ok = 1; io.bus_rdata = 32'hAAAA5555;
    @(negedge clk);
    chk("c3_next_data_ok", 32'(io.inst_data_ok), 32'd1);
    chk("c3_next_rdata", io.inst_rdata, 32'hAAAA5555);
    next_cycle();
    io.bus_data_ok = 0;
    next_cycle();

    // 4: load with address and data handshakes in one cycle, then a spurious response
    io.data_req = 1; io.data_wr = 0; io.data_size = 2'd2; io.data_addr = 32'h80000020;
    io.data_wstrb = 4'h0; io.data_wdata = 32'h0;
    next_cycle();
    io.bus_addr_ok = 1; io.bus_data_ok = 1; io.bus_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("l4_data_addr_ok", 32'(io.data_addr_ok), 32'd1);
    chk("l4_data_data_ok", 32'(io.data_data_ok), 32'd1);
    chk("l4_data_rdata", io.data_rdata, 32'hDEADBEEF);
    next_cycle();
    io.data_req = 0; io.bus_addr_ok = 0; io.bus_data_ok = 1; io.bus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("l4_idle_busy", 32'(io.busy), 32'd0);
    chk("l4_spurious_data_ok", 32'(io.data_data_ok), 32'd0);
    chk("l4_spurious_inst_ok", 32'(io.inst_data_ok), 32'd0);
    next_cycle();
    io.bus_data_ok = 0;
    next_cycle();

    // 5: byte store held in ADDR for five cycles
    io.data_req = 1; io.data_wr = 1; io.data_size = 2'd0; io.data_addr = 32'h80000031;
    io.data_wstrb = 4'h2; io.data_wdata = 32'h0000AB00;
    next_cycle();
    io.data_wdata = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("w5_bus_req", 32'(io.bus_req), 32'd1);
      chk("w5_bus_addr", io.bus_addr, 32'h80000031);
      chk("w5_bus_wdata", io.bus_wdata, 32'h0000AB00);
      chk("w5_bus_size", 32'(io.bus_size), 32'd0);
      chk("w5_no_addr_ok", 32'(io.data_addr_ok), 32'd0);
      chk("w5_no_data_ok", 32'(io.data_data_ok), 32'd0);
      next_cycle();
    end
    io.bus_addr_ok = 1;
    @(negedge clk);
    chk("w5_data_addr_ok", 32'(io.data_addr_ok), 32'd1);
    next_cycle();
    io.data_req = 0; io.bus_addr_ok = 0; io.bus_data_ok = 1;
    @(negedge clk);
    chk("w5_data_data_ok", 32'(io.data_data_ok), 32'd1);
    next_cycle();
    io.bus_data_ok = 0;
    next_cycle();

    // 6: reset asserted while a fetch waits for data
    io.inst_req = 1; io.inst_addr = 32'hBFC00010;
    next_cycle();
    io.bus_addr_ok = 1;
    next_cycle();
    io.inst_req = 0; io.bus_addr_ok = 0;
    @(negedge clk);
    chk("r6_pre_busy", 32'(io.busy), 32'd1);
    next_cycle();
    rst = 1'b0;
    #1;
    chk("r6_busy", 32'(io.busy), 32'd0);
    chk("r6_bus_addr", io.bus_addr, 32'd0);
    chk("r6_bus_req", 32'(io.bus_req), 32'd0);
    io.bus_data_ok = 1; io.bus_rdata = 32'h55AA55AA;
    @(negedge clk);
    chk("r6_in_rst_data_ok", 32'(io.inst_data_ok), 32'd0);
    chk("r6_in_rst_rdata", io.inst_rdata, 32'd0);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("r6_after_data_ok", 32'(io.inst_data_ok), 32'd0);
    chk("r6_after_busy", 32'(io.busy), 32'd0);
    next_cycle();
    io.bus_data_ok = 0;
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
